// File: rtl/result_pkg.sv
// Shared definitions for the result stream: collector FSM states and header layout.
// The header field positions are shared with the serializer so both ends agree.
package result_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WORD_A = 2'd1,
        WORD_B = 2'd2,
        CHECK  = 2'd3
    } rc_state_t;

    localparam int RC_DATA_BYTES = 8;

    localparam int HDR_SYNC_MSB = 7;
    localparam int HDR_SYNC_LSB = 4;
    localparam int HDR_RSV_BIT  = 3;
    localparam int HDR_MODE_MSB = 2;
    localparam int HDR_MODE_LSB = 0;

endpackage

// File: rtl/result_collector_gap_timer.sv
// gap_timer: 16-bit saturating idle counter with clear, count enable and an
// expired flag at TIMEOUT_CYCLES.
module gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic expired_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if (clr_i) begin
            cnt_q <= 16'd0;
        end else if (cnt_en_i && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired_o = (cnt_q >= 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/result_collector.sv
// result_collector: reassembles header/kappa/inverse-kappa frames from a byte stream.
// Optional trailing XOR checksum byte is built when RESULT_COLLECTOR_CHECKSUM_EN is defined.
module result_collector
    import result_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [3:0]  SYNC_NIBBLE    = 4'hA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic [2:0]  mode,
    output logic [31:0] word_a,
    output logic [31:0] word_b,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);

    rc_state_t   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  msh_q, msh_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  mode_q, mode_d;
    logic [31:0] wa_q, wa_d;
    logic [31:0] wb_q, wb_d;
    logic        fv_q, fv_d;
    logic        fe_q, fe_d;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
`endif

    logic accept;
    logic expired;
    logic timeout;
    logic in_frame;

    assign accept   = ena & in_valid;
    assign in_frame = (state_q != IDLE);
    // An accepted byte on the expiry cycle wins over the timeout
    assign timeout  = ena & ~accept & in_frame & expired;

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (ena & (accept | ~in_frame)),
        .cnt_en_i (ena & in_frame),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        msh_d   = msh_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        wa_d    = wa_q;
        wb_d    = wb_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
        xor_d   = xor_q ^ in_byte;
`endif
        if (timeout) begin
            state_d = IDLE;
            fe_d    = 1'b1;
        end else if (accept) begin
            case (state_q)
                IDLE: begin
                    if (in_byte[HDR_SYNC_MSB:HDR_SYNC_LSB] == SYNC_NIBBLE) begin
                        msh_d   = in_byte[HDR_MODE_MSB:HDR_MODE_LSB];
                        cnt_d   = 2'd0;
                        state_d = WORD_A;
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
                        xor_d   = in_byte;
`endif
                    end
                end
                WORD_A: begin
                    a_d   = {a_q[23:0], in_byte};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = WORD_B;
                end
                WORD_B: begin
                    b_d   = {b_q[23:0], in_byte};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
                        state_d = CHECK;
`else
                        mode_d  = msh_q;
                        wa_d    = a_q;
                        wb_d    = b_d;
                        fv_d    = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
`ifdef RESULT_COLLECTOR_CHECKSUM_EN
                CHECK: begin
                    if (in_byte == xor_q) begin
                        mode_d = msh_q;
                        wa_d   = a_q;
                        wb_d   = b_q;
                        fv_d   = 1'b1;
                    end else begin
                        fe_d   = 1'b1;
                    end
                    state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        if (!ena) begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            msh_q   <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            mode_q  <= 3'd0;
            wa_q    <= 32'd0;
            wb_q    <= 32'd0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            msh_q   <= msh_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            wa_q    <= wa_d;
            wb_q    <= wb_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
        end
    end

`ifdef RESULT_COLLECTOR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= 8'd0;
        end else if (accept) begin
            xor_q <= xor_d;
        end
    end
`endif

    assign mode        = mode_q;
    assign word_a      = wa_q;
    assign word_b      = wb_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign busy        = in_frame;

endmodule
